// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single 8-bit system memory port between the 8088 CPU core and the
// video scan-out fetcher. Video has fixed priority. A starvation guard hands the
// next slot to a waiting CPU after STARVE consecutive video grants.
// Each access runs IDLE -> ACCESS (LAT cycles) -> DONE (one-cycle ack) -> IDLE.
module mem_arbiter #(
    parameter int AW     = 20,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_rdata,
    output logic          vid_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    // Counter only has to hold LAT-1; streak saturates at STARVE.
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_streak;
    logic            r_owner_cpu;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [7:0]      r_mem_wdata;
    logic [7:0]      r_cpu_rdata;
    logic [7:0]      r_vid_rdata;
    logic            r_cpu_ack;
    logic            r_vid_ack;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [SW-1:0]   w_streak_nxt;
    logic            w_owner_cpu_nxt;
    logic            w_mem_en_nxt;
    logic            w_mem_we_nxt;
    logic [AW-1:0]   w_mem_addr_nxt;
    logic [7:0]      w_mem_wdata_nxt;
    logic [7:0]      w_cpu_rdata_nxt;
    logic [7:0]      w_vid_rdata_nxt;
    logic            w_cpu_ack_nxt;
    logic            w_vid_ack_nxt;

    logic            w_any_req;
    logic            w_cpu_wins;

    // Video wins every collision except when the CPU has already waited
    // through STARVE consecutive video grants.
    assign w_any_req  = cpu_req | vid_req;
    assign w_cpu_wins = cpu_req & (~vid_req | (r_streak == STREAK_MAX));

    // Next-state and next-register values for the access sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_streak_nxt    = r_streak;
        w_owner_cpu_nxt = r_owner_cpu;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_vid_rdata_nxt = r_vid_rdata;
        w_cpu_ack_nxt   = 1'b0;
        w_vid_ack_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = S_ACCESS;
                    w_mem_en_nxt    = 1'b1;
                    w_cnt_nxt       = CNT_LOAD;
                    w_owner_cpu_nxt = w_cpu_wins;
                    if (w_cpu_wins) begin
                        w_mem_addr_nxt  = cpu_addr;
                        w_mem_wdata_nxt = cpu_wdata;
                        w_mem_we_nxt    = cpu_we;
                        w_streak_nxt    = '0;
                    end else begin
                        w_mem_addr_nxt  = vid_addr;
                        w_mem_we_nxt    = 1'b0;
                        // Only grants that make a waiting CPU wait longer count.
                        if (cpu_req && (r_streak != STREAK_MAX)) begin
                            w_streak_nxt = r_streak + 1'b1;
                        end
                    end
                end
            end

            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = S_DONE;
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (r_owner_cpu) begin
                        w_cpu_ack_nxt = 1'b1;
                        // A write leaves the last read value on cpu_rdata.
                        if (!r_mem_we) begin
                            w_cpu_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        w_vid_ack_nxt   = 1'b1;
                        w_vid_rdata_nxt = mem_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_owner_cpu <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_streak    <= w_streak_nxt;
            r_owner_cpu <= w_owner_cpu_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_vid_rdata <= w_vid_rdata_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_vid_ack   <= w_vid_ack_nxt;
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign vid_rdata = r_vid_rdata;
    assign vid_ack   = r_vid_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

    // Port-level invariants: writes only for the CPU, single-cycle acks,
    // and never two of {cpu_ack, vid_ack, mem_en} at once.
    a_we_owner : assert property (@(posedge clock) disable iff (!reset_n)
        mem_we |-> (mem_en && r_owner_cpu));
    a_cpu_ack_pulse : assert property (@(posedge clock) disable iff (!reset_n)
        cpu_ack |=> !cpu_ack);
    a_vid_ack_pulse : assert property (@(posedge clock) disable iff (!reset_n)
        vid_ack |=> !vid_ack);
    a_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0({cpu_ack, vid_ack, mem_en}));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter: a small RAM, directed requester stimulus, and a
// timeline model of the arbiter (grant edge + fixed offsets) compared against
// the DUT at every falling clock edge.
module tb_mem_arbiter;

    localparam int AW     = 20;
    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_rdata;
    logic          vid_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;

    mem_arbiter #(.AW(AW), .LAT(LAT), .STARVE(STARVE)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
        .vid_ack(vid_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Simple RAM behind the port: synchronous write, combinational read.
    bit [7:0] ram [4096];
    always @(posedge clock) begin
        if (mem_en && mem_we) ram[mem_addr[11:0]] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr[11:0]];

    // ---------------- timeline model ----------------
    int          e;          // rising edges since reset release
    int          free_at;    // first edge at which a new grant may happen
    int          g_at;       // edge of the most recent grant
    bit          g_valid;
    bit          g_cpu;
    bit          g_we;
    logic [AW-1:0] g_addr;
    logic [7:0]  g_wdata;
    int          streak_m;
    logic [7:0]  mmem [int];
    bit          exp_mem_en, exp_mem_we, exp_cpu_ack, exp_vid_ack, exp_busy;
    logic [7:0]  exp_cpu_rdata, exp_vid_rdata;

    function automatic logic [7:0] mrd(input logic [AW-1:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : 8'h00;
    endfunction

    task automatic model_reset();
        e = 0; free_at = 0; g_at = -100; g_valid = 0; g_cpu = 0; g_we = 0;
        g_addr = '0; g_wdata = '0; streak_m = 0;
        exp_mem_en = 0; exp_mem_we = 0; exp_cpu_ack = 0; exp_vid_ack = 0;
        exp_busy = 0; exp_cpu_rdata = 8'h00; exp_vid_rdata = 8'h00;
    endtask

    // Advance the model by one rising edge using the inputs that were stable
    // across that edge.
    task automatic model_edge();
        bit cw;
        e = e + 1;
        if (g_valid && e == g_at + LAT) begin
            if (g_cpu) begin
                if (g_we) mmem[int'(g_addr)] = g_wdata;
                else      exp_cpu_rdata = mrd(g_addr);
            end else begin
                exp_vid_rdata = mrd(g_addr);
            end
        end
        if (e >= free_at && (cpu_req || vid_req)) begin
            cw = cpu_req && (!vid_req || streak_m == STARVE);
            if (cw) streak_m = 0;
            else if (cpu_req && streak_m < STARVE) streak_m = streak_m + 1;
            g_valid = 1; g_at = e; g_cpu = cw; g_we = cw && cpu_we;
            g_addr  = cw ? cpu_addr : vid_addr;
            g_wdata = cpu_wdata;
            free_at = e + LAT + 2;
        end
        exp_mem_en  = g_valid && e >= g_at && e < g_at + LAT;
        exp_mem_we  = exp_mem_en && g_we;
        exp_cpu_ack = g_valid && g_cpu  && e == g_at + LAT;
        exp_vid_ack = g_valid && !g_cpu && e == g_at + LAT;
        exp_busy    = g_valid && e >= g_at && e <= g_at + LAT;
    endtask

    // ---------------- checking ----------------
    int  n_checks = 0;
    int  n_err    = 0;
    int  tick     = 0;
    int  n_cpu_acks = 0;
    int  n_vid_acks = 0;
    int  cpu_ack_tick = -1;
    int  vid_ack_tick = -1;
    int  vid_ticks[$];
    byte seq[$];
    bit  vid_hold = 0;
    bit  prev_cpu_ack = 0;
    bit  prev_vid_ack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: update model, compare every output, play the requesters.
    task automatic step();
        @(negedge clock);
        tick++;
        if (!reset_n) model_reset();
        else          model_edge();
        chk("cpu_ack",   32'(cpu_ack),   32'(exp_cpu_ack));
        chk("vid_ack",   32'(vid_ack),   32'(exp_vid_ack));
        chk("mem_en",    32'(mem_en),    32'(exp_mem_en));
        chk("mem_we",    32'(mem_we),    32'(exp_mem_we));
        chk("busy",      32'(busy),      32'(exp_busy));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rdata));
        chk("vid_rdata", 32'(vid_rdata), 32'(exp_vid_rdata));
        if (exp_mem_en) chk("mem_addr", 32'(mem_addr), 32'(g_addr));
        if (exp_mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
        chk("we_owner", 32'(mem_we && !(mem_en && g_cpu)), 32'(0));
        chk("ack_pulse", 32'((cpu_ack && prev_cpu_ack) || (vid_ack && prev_vid_ack)), 32'(0));
        chk("onehot0", 32'($countones({cpu_ack, vid_ack, mem_en}) > 1), 32'(0));
        prev_cpu_ack = cpu_ack;
        prev_vid_ack = vid_ack;
        if (cpu_ack) begin
            n_cpu_acks++; cpu_ack_tick = tick; seq.push_back("C");
            cpu_req = 1'b0;
        end
        if (vid_ack) begin
            n_vid_acks++; vid_ack_tick = tick; vid_ticks.push_back(tick); seq.push_back("V");
            if (!vid_hold) vid_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    t0;
        int    n0;
        int    we_cnt;
        string exp_seq;

        model_reset();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_outputs", 32'({cpu_ack, vid_ack, mem_en, mem_we, busy, cpu_rdata, vid_rdata}), 32'(0));
        #2 reset_n = 1'b1;
        step();

        // CPU write 0x12345 <= 0xA5
        cpu_we = 1; cpu_addr = 20'h12345; cpu_wdata = 8'hA5; cpu_req = 1;
        t0 = tick; n0 = n_cpu_acks; we_cnt = 0;
        for (int i = 0; i < 20 && n_cpu_acks == n0; i++) begin
            step();
            if (mem_we) we_cnt++;
        end
        chk("wr_ack_latency", 32'(tick - t0), 32'(3));
        chk("wr_we_cycles", 32'(we_cnt), 32'(2));
        step();

        // CPU read 0x12345
        cpu_we = 0; cpu_req = 1;
        t0 = tick; n0 = n_cpu_acks;
        for (int i = 0; i < 20 && n_cpu_acks == n0; i++) step();
        chk("rd_ack_latency", 32'(tick - t0), 32'(3));
        chk("rd_data", 32'(cpu_rdata), 32'h0000_00A5);
        step();

        // Collision: CPU write 0x00777 <= 0x3C, video read 0x12345
        cpu_we = 1; cpu_addr = 20'h00777; cpu_wdata = 8'h3C;
        vid_addr = 20'h12345;
        cpu_req = 1; vid_req = 1;
        t0 = tick; n0 = n_cpu_acks; vid_ack_tick = -1;
        for (int i = 0; i < 30 && n_cpu_acks == n0; i++) step();
        chk("coll_vid_latency", 32'(vid_ack_tick - t0), 32'(3));
        chk("coll_cpu_gap", 32'(cpu_ack_tick - vid_ack_tick), 32'(4));
        chk("coll_vid_rdata", 32'(vid_rdata), 32'h0000_00A5);
        step();

        // Video-only stream from 0x00777
        vid_hold = 1; vid_addr = 20'h00777; vid_req = 1;
        vid_ticks.delete();
        n0 = n_vid_acks;
        for (int i = 0; i < 40 && n_vid_acks < n0 + 4; i++) step();
        chk("vstream_count", 32'(vid_ticks.size()), 32'(4));
        for (int i = 1; i < vid_ticks.size(); i++) begin
            chk("vstream_gap", 32'(vid_ticks[i] - vid_ticks[i-1]), 32'(4));
        end
        chk("vstream_rdata", 32'(vid_rdata), 32'h0000_003C);
        vid_hold = 0;
        n0 = n_vid_acks;
        for (int i = 0; i < 20 && n_vid_acks == n0; i++) step();
        chk("vstream_stop", 32'(vid_req), 32'(0));
        repeat (2) step();

        // Starvation guard, then a second round to show the streak restarted
        seq.delete();
        cpu_we = 0; cpu_addr = 20'h00777; vid_addr = 20'h12345;
        vid_hold = 1; cpu_req = 1; vid_req = 1;
        n0 = n_cpu_acks;
        for (int i = 0; i < 80 && n_cpu_acks < n0 + 2; i++) begin
            step();
            if (cpu_ack && n_cpu_acks == n0 + 1) cpu_req = 1;
        end
        chk("starve_seq_len", 32'(seq.size()), 32'(10));
        exp_seq = "VVVVCVVVVC";
        for (int i = 0; i < 10 && i < seq.size(); i++) begin
            chk("starve_seq", 32'(seq[i]), 32'(exp_seq[i]));
        end
        chk("starve_cpu_rdata", 32'(cpu_rdata), 32'h0000_003C);
        vid_hold = 0;
        for (int i = 0; i < 20 && vid_req; i++) step();
        chk("starve_stop", 32'(vid_req), 32'(0));
        repeat (2) step();

        // Reset in the middle of a CPU read
        cpu_we = 0; cpu_addr = 20'h00ABC; cpu_req = 1;
        step();
        chk("abort_pre_mem_en", 32'(mem_en), 32'(1));
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_acks", 32'({cpu_ack, vid_ack}), 32'(0));
        chk("abort_rdata", 32'({cpu_rdata, vid_rdata}), 32'(0));
        cpu_req = 0;
        repeat (2) step();
        #2 reset_n = 1'b1;
        n0 = n_cpu_acks;
        repeat (8) step();
        chk("abort_no_ack", 32'(n_cpu_acks - n0), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
